// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding,
// default base address and wait-counter width.
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [31:0] DEF_ADDR_BASE = 32'h1001_0000;
   localparam int          CNT_W         = 4;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core data-port bus: request side driven by the core, response side by the controller.
interface dmem_ctrl_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] dAddress;
   logic [31:0] dWriteData;
   logic [31:0] dReadData;
   logic        dReady;
   logic        dError;

   modport master (
      output MemRead, MemWrite, dAddress, dWriteData,
      input  dReadData, dReady, dError
   );

   modport slave (
      input  MemRead, MemWrite, dAddress, dWriteData,
      output dReadData, dReady, dError
   );
endinterface

// File: rtl/dmem_ctrl_array.sv
// Single-port synchronous word RAM with registered read; storage is not reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Read data only moves on an enabled read, so it holds between loads.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: request decode, wait-state sequencing and error
// response in front of a word-addressed RAM.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic      clk,
   input  logic      rst,
   dmem_ctrl_if.slave bus
);

   localparam int              IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [31:0]     SPAN     = 32'(DEPTH_WORDS) << 2;
   localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             wr_q, wr_d;
   logic             rd_valid_q, rd_valid_d;

   logic [31:0]      offset;
   logic [IDX_W-1:0] in_idx;
   logic             req;
   logic             bad;

   logic             mem_en;
   logic             mem_we;
   logic [IDX_W-1:0] mem_addr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;

   // Addresses below the base wrap to huge offsets and fail the range test.
   assign offset = bus.dAddress - ADDR_BASE;
   assign in_idx = offset[IDX_W+1:2];
   assign req    = bus.MemRead | bus.MemWrite;
   assign bad    = (bus.MemRead & bus.MemWrite) | (offset >= SPAN) | (bus.dAddress[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      rd_valid_d = rd_valid_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = idx_q;
      mem_wdata  = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (bad) begin
                  state_d = S_ERR;
               end else begin
                  idx_d   = in_idx;
                  wdata_d = bus.dWriteData;
                  wr_d    = bus.MemWrite;
                  if (WAIT_CYCLES == 0) begin
                     mem_en     = 1'b1;
                     mem_we     = bus.MemWrite;
                     mem_addr   = in_idx;
                     mem_wdata  = bus.dWriteData;
                     rd_valid_d = rd_valid_q | bus.MemRead;
                     state_d    = S_RESP;
                  end else begin
                     cnt_d   = CNT_INIT;
                     state_d = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               mem_en     = 1'b1;
               mem_we     = wr_q;
               rd_valid_d = rd_valid_q | ~wr_q;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .en_i    (mem_en),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   // The RAM read register is not reset; gate it until a read has completed.
   assign bus.dReadData = rd_valid_q ? mem_rdata : 32'h0;
   assign bus.dReady    = (state_q == S_RESP);
   assign bus.dError    = (state_q == S_ERR);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a WAIT_CYCLES=2 instance driven from a vector
// table plus reset-abort, and a WAIT_CYCLES=0 instance for zero-latency access.
module tb_dmem_ctrl;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   dmem_ctrl_if bus0 ();
   dmem_ctrl_if bus1 ();

   dmem_ctrl #(.WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   dmem_ctrl #(.WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [13];

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (sel) begin
         bus1.MemRead = rd; bus1.MemWrite = wr; bus1.dAddress = addr; bus1.dWriteData = wdata;
      end else begin
         bus0.MemRead = rd; bus0.MemWrite = wr; bus0.dAddress = addr; bus0.dWriteData = wdata;
      end
   endtask

   task automatic access(input bit sel, input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input int exp_lat, input logic [31:0] exp_data);
      int          lat;
      logic        got_rdy;
      logic        got_err;
      logic [31:0] got_data;
      lat = 0;
      got_rdy = 1'b0;
      got_err = 1'b0;
      got_data = '0;
      @(negedge clk);
      drive(sel, rd, wr, addr, wdata);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         got_rdy  = sel ? bus1.dReady    : bus0.dReady;
         got_err  = sel ? bus1.dError    : bus0.dError;
         got_data = sel ? bus1.dReadData : bus0.dReadData;
         if (got_rdy || got_err) begin
            lat = c;
            break;
         end
      end
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      if (lat == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: no dReady/dError within 20 cycles", name);
      end else begin
         check32({name, " resp_err"}, {31'h0, got_err}, {31'h0, exp_err});
         check32({name, " latency"}, 32'(lat), 32'(exp_lat));
         check32({name, " rdata"}, got_data, exp_data);
      end
      @(posedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      //         rd    wr    addr           wdata          err  lat  dReadData at response
      vecs[0]  = '{1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 3, 32'h0000_0000};
      vecs[1]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 3, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 1'b0, 32'h1001_0002, 32'h0,         1'b1, 1, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b0, 32'h1001_1000, 32'h0,         1'b1, 1, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 1'b1, 32'h1001_0FFC, 32'hAAAA_1111, 1'b0, 3, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b0, 1'b1, 32'h1000_FFFC, 32'h5555_5555, 1'b1, 1, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b1, 1'b0, 32'h1001_0FFC, 32'h0,         1'b0, 3, 32'hAAAA_1111};
      vecs[7]  = '{1'b0, 1'b1, 32'h1001_0000, 32'h0101_0101, 1'b0, 3, 32'hAAAA_1111};
      vecs[8]  = '{1'b1, 1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'hAAAA_1111};
      vecs[9]  = '{1'b1, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 3, 32'h0101_0101};
      vecs[10] = '{1'b0, 1'b1, 32'h1001_0010, 32'hAAAA_5555, 1'b0, 3, 32'h0101_0101};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 1, 32'h0101_0101};
      vecs[12] = '{1'b1, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 3, 32'hDEAD_BEEF};

      repeat (3) @(posedge clk);
      #1;
      check32("reset dReady",    {31'h0, bus0.dReady}, 32'h0);
      check32("reset dError",    {31'h0, bus0.dError}, 32'h0);
      check32("reset dReadData", bus0.dReadData,       32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         access(1'b0, $sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_data);
      end

      // Reset while a write sits in WAIT: the old word must survive.
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'h1001_0010, 32'h1234_5678);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check32("abort dReady",    {31'h0, bus0.dReady}, 32'h0);
      check32("abort dError",    {31'h0, bus0.dError}, 32'h0);
      check32("abort dReadData", bus0.dReadData,       32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      access(1'b0, "abort readback", 1'b1, 1'b0, 32'h1001_0010, 32'h0, 1'b0, 3, 32'hAAAA_5555);

      access(1'b1, "w0 write", 1'b0, 1'b1, 32'h1001_0004, 32'h0000_0005, 1'b0, 1, 32'h0);
      access(1'b1, "w0 read",  1'b1, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 1, 32'h0000_0005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
